// File: rtl/sel_mux_scan.sv
// sel_mux_scan: N-channel, W-bit selector with a registered output.
// Manual mode follows an external select. Auto-scan mode steps through the
// channels, holding each one for DWELL cycles.
module sel_mux_scan #(
   parameter int CH    = 4,
   parameter int W     = 1,
   parameter int DWELL = 100,
   parameter int SEL_W = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH*W-1:0]   in,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic              hold,
   output logic [W-1:0]      out,
   output logic [SEL_W-1:0]  cur_sel,
   output logic              out_valid,
   output logic              wrap
);

   localparam int               CNT_W    = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH - 1);

   typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
   logic [W-1:0]      out_d;
   logic [SEL_W-1:0]  cur_sel_d;
   logic              valid_d, wrap_d;
   logic              sel_ok;

   // Channel mux written as a loop so select values >= CH never index
   // past the packed input vector; they return zero.
   function automatic logic [W-1:0] pick(input logic [CH*W-1:0] v,
                                         input logic [SEL_W-1:0] idx);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < CH; k++)
         if (idx == SEL_W'(k)) r = v[k*W +: W];
      return r;
   endfunction

   assign sel_ok = (int'(sel) < CH);

   // Next-state and next-output logic; the transition edge already performs
   // the action of the state being entered, so decode on state_d.
   always_comb begin
      state_d   = mode ? SCAN : MANUAL;
      cnt_d     = cnt_q;
      cur_sel_d = cur_sel;
      out_d     = out;
      valid_d   = out_valid;
      wrap_d    = 1'b0;
      // Coming from MANUAL the dwell count starts fresh, so the current
      // channel gets a full DWELL before the first step.
      cnt_base  = (state_q == SCAN) ? cnt_q : '0;

      if (state_d == MANUAL) begin
         cnt_d = '0;
         if (sel_ok) begin
            cur_sel_d = sel;
            out_d     = pick(in, sel);
            valid_d   = 1'b1;
         end else begin
            out_d   = '0;
            valid_d = 1'b0;
         end
      end else begin
         // Output follows the channel selected before this edge's step.
         out_d   = pick(in, cur_sel);
         valid_d = 1'b1;
         cnt_d   = cnt_base;
         if (!hold) begin
            if (cnt_base == CNT_LAST) begin
               cnt_d     = '0;
               cur_sel_d = (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
               wrap_d    = (cur_sel == SEL_LAST);
            end else begin
               cnt_d = cnt_base + CNT_W'(1);
            end
         end
      end
   end

   // State, dwell counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= MANUAL;
         cnt_q     <= '0;
         cur_sel   <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_sel   <= cur_sel_d;
         out       <= out_d;
         out_valid <= valid_d;
         wrap      <= wrap_d;
      end
   end

endmodule

// File: tb/tb_sel_mux_scan.sv
// Bench for sel_mux_scan: two instances (CH=4/W=1/DWELL=4 and
// CH=3/W=4/DWELL=1) driven by directed vectors; expected values go into a
// per-instance queue and a monitor on the falling edge checks them.
module tb_sel_mux_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: CH=4, W=1, DWELL=4
   logic        rst_a;
   logic [3:0]  in_a;
   logic        mode_a, hold_a;
   logic [1:0]  sel_a;
   logic [0:0]  out_a;
   logic [1:0]  cs_a;
   logic        v_a, w_a;

   // Instance B: CH=3, W=4, DWELL=1
   logic        rst_b;
   logic [11:0] in_b;
   logic        mode_b, hold_b;
   logic [1:0]  sel_b;
   logic [3:0]  out_b;
   logic [1:0]  cs_b;
   logic        v_b, w_b;

   sel_mux_scan #(.CH(4), .W(1), .DWELL(4)) dut_a (
      .clk(clk), .rst_n(rst_a), .in(in_a), .mode(mode_a), .sel(sel_a),
      .hold(hold_a), .out(out_a), .cur_sel(cs_a), .out_valid(v_a), .wrap(w_a));

   sel_mux_scan #(.CH(3), .W(4), .DWELL(1)) dut_b (
      .clk(clk), .rst_n(rst_b), .in(in_b), .mode(mode_b), .sel(sel_b),
      .hold(hold_b), .out(out_b), .cur_sel(cs_b), .out_valid(v_b), .wrap(w_b));

   typedef struct {
      logic [3:0] o;
      logic [1:0] cs;
      logic       v;
      logic       w;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitors: one popped expectation per falling edge.
   always @(negedge clk) begin
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         chk("a.out",       32'(out_a), 32'(ea.o));
         chk("a.cur_sel",   32'(cs_a),  32'(ea.cs));
         chk("a.out_valid", 32'(v_a),   32'(ea.v));
         chk("a.wrap",      32'(w_a),   32'(ea.w));
      end
   end

   always @(negedge clk) begin
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         chk("b.out",       32'(out_b), 32'(eb.o));
         chk("b.cur_sel",   32'(cs_b),  32'(eb.cs));
         chk("b.out_valid", 32'(v_b),   32'(eb.v));
         chk("b.wrap",      32'(w_b),   32'(eb.w));
      end
   end

   // Drive one cycle of A inputs and queue the result expected after the next edge.
   task automatic va(input logic [3:0] i, input logic m, input logic [1:0] s,
                     input logic h, input logic eo, input logic [1:0] ecs,
                     input logic ev, input logic ew);
      exp_t e;
      @(negedge clk); #1;
      in_a = i; mode_a = m; sel_a = s; hold_a = h;
      e.o = {3'b000, eo}; e.cs = ecs; e.v = ev; e.w = ew;
      qa.push_back(e);
   endtask

   // A in auto-scan, in=1010, no hold
   task automatic sa(input logic eo, input logic [1:0] ecs, input logic ew);
      va(4'b1010, 1'b1, 2'd0, 1'b0, eo, ecs, 1'b1, ew);
   endtask

   task automatic vb(input logic r, input logic [11:0] i, input logic m,
                     input logic [1:0] s, input logic h, input logic [3:0] eo,
                     input logic [1:0] ecs, input logic ev, input logic ew);
      exp_t e;
      @(negedge clk); #1;
      rst_b = r; in_b = i; mode_b = m; sel_b = s; hold_b = h;
      e.o = eo; e.cs = ecs; e.v = ev; e.w = ew;
      qb.push_back(e);
   endtask

   task automatic sb(input logic [3:0] eo, input logic [1:0] ecs, input logic ew);
      vb(1'b1, 12'hCBA, 1'b1, 2'd0, 1'b0, eo, ecs, 1'b1, ew);
   endtask

   // Async reset on B between edges; outputs must clear with no clock edge.
   task automatic async_rst_b();
      @(negedge clk); #3;
      rst_b = 1'b0;
      #1;
      chk("b.arst.out",       32'(out_b), 32'h0);
      chk("b.arst.cur_sel",   32'(cs_b),  32'h0);
      chk("b.arst.out_valid", 32'(v_b),   32'h0);
      chk("b.arst.wrap",      32'(w_b),   32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_a = 1'b0; in_a = 4'b1010; mode_a = 1'b0; sel_a = 2'd0; hold_a = 1'b0;
      rst_b = 1'b0; in_b = 12'hCBA; mode_b = 1'b0; sel_b = 2'd0; hold_b = 1'b0;

      // Reset state with the clock running
      repeat (3) @(negedge clk);
      chk("a.rst.out",       32'(out_a), 32'h0);
      chk("a.rst.cur_sel",   32'(cs_a),  32'h0);
      chk("a.rst.out_valid", 32'(v_a),   32'h0);
      chk("b.rst.out",       32'(out_b), 32'h0);
      chk("b.rst.out_valid", 32'(v_b),   32'h0);
      #1 rst_a = 1'b1;
      @(negedge clk);
      chk("a.rel.out",       32'(out_a), 32'h0);
      chk("a.rel.out_valid", 32'(v_a),   32'h1);

      // ---------------- A: manual sweep, in=1010
      va(4'b1010, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      va(4'b1010, 1'b0, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
      va(4'b1010, 1'b0, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
      va(4'b1010, 1'b0, 2'd3, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
      va(4'b1010, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

      // ---------------- A: auto-scan from channel 0
      sa(1'b0, 2'd0, 1'b0); sa(1'b0, 2'd0, 1'b0); sa(1'b0, 2'd0, 1'b0);
      sa(1'b0, 2'd1, 1'b0);
      sa(1'b1, 2'd1, 1'b0); sa(1'b1, 2'd1, 1'b0); sa(1'b1, 2'd1, 1'b0);
      sa(1'b1, 2'd2, 1'b0);
      sa(1'b0, 2'd2, 1'b0);                         // cur_sel=2, counter=1
      // hold for 10 cycles
      for (int i = 0; i < 10; i++)
         va(4'b1010, 1'b1, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
      sa(1'b0, 2'd2, 1'b0); sa(1'b0, 2'd2, 1'b0);
      sa(1'b0, 2'd3, 1'b0);                         // step 3 edges after release
      sa(1'b1, 2'd3, 1'b0); sa(1'b1, 2'd3, 1'b0); sa(1'b1, 2'd3, 1'b0);
      sa(1'b1, 2'd0, 1'b1);                         // 3->0, wrap pulse
      sa(1'b0, 2'd0, 1'b0); sa(1'b0, 2'd0, 1'b0); sa(1'b0, 2'd0, 1'b0);
      sa(1'b0, 2'd1, 1'b0);
      sa(1'b1, 2'd1, 1'b0); sa(1'b1, 2'd1, 1'b0); sa(1'b1, 2'd1, 1'b0);
      sa(1'b1, 2'd2, 1'b0);
      sa(1'b0, 2'd2, 1'b0); sa(1'b0, 2'd2, 1'b0); sa(1'b0, 2'd2, 1'b0);
      sa(1'b0, 2'd3, 1'b0);
      sa(1'b1, 2'd3, 1'b0);                         // scanning at cur_sel=3

      // ---------------- A: mode switch
      va(4'b1010, 1'b0, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
      sa(1'b1, 2'd1, 1'b0); sa(1'b1, 2'd1, 1'b0); sa(1'b1, 2'd1, 1'b0);
      sa(1'b1, 2'd2, 1'b0);                         // first step 4 edges after entry
      sa(1'b0, 2'd2, 1'b0);
      // input change visible one cycle later
      va(4'b0101, 1'b0, 2'd1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
      va(4'b0101, 1'b0, 2'd2, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);

      // ---------------- B: CH=3, W=4, DWELL=1, in=CBA
      vb(1'b1, 12'hCBA, 1'b0, 2'd3, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
      vb(1'b1, 12'hCBA, 1'b0, 2'd1, 1'b0, 4'hB, 2'd1, 1'b1, 1'b0);
      vb(1'b1, 12'hCBA, 1'b0, 2'd3, 1'b0, 4'h0, 2'd1, 1'b0, 1'b0);
      vb(1'b1, 12'hCBA, 1'b0, 2'd0, 1'b0, 4'hA, 2'd0, 1'b1, 1'b0);
      sb(4'hA, 2'd1, 1'b0); sb(4'hB, 2'd2, 1'b0); sb(4'hC, 2'd0, 1'b1);
      sb(4'hA, 2'd1, 1'b0); sb(4'hB, 2'd2, 1'b0); sb(4'hC, 2'd0, 1'b1);
      sb(4'hA, 2'd1, 1'b0);
      vb(1'b1, 12'hCBA, 1'b1, 2'd0, 1'b1, 4'hB, 2'd1, 1'b1, 1'b0);
      vb(1'b1, 12'hCBA, 1'b1, 2'd0, 1'b1, 4'hB, 2'd1, 1'b1, 1'b0);
      sb(4'hB, 2'd2, 1'b0);
      async_rst_b();
      // release with mode=1: scanning restarts at channel 0
      sb(4'hA, 2'd1, 1'b0); sb(4'hB, 2'd2, 1'b0); sb(4'hC, 2'd0, 1'b1);
      async_rst_b();
      // release with mode=0: manual select
      vb(1'b1, 12'hCBA, 1'b0, 2'd2, 1'b0, 4'hC, 2'd2, 1'b1, 1'b0);

      // Drain scoreboards with a bound
      for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++)
         @(negedge clk);
      chk("drain.qa", 32'(qa.size()), 32'h0);
      chk("drain.qb", 32'(qb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
